// File: rtl/router_pkg.sv
// Shared router definitions: packet layout, default widths and arbiter state encoding.
package router_pkg;

    localparam int unsigned DefUwidth   = 8;
    localparam int unsigned DefPtrInSz  = 4;

    localparam int unsigned OffSrc      = 0;
    localparam int unsigned OffDst      = 1;
    localparam int unsigned OffSize     = 2;
    localparam int unsigned OffData     = 3;
    localparam int unsigned MaxPktWords = 11;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

    // The CRC word follows the payload, so its offset depends on the packet size field.
    function automatic int unsigned crc_offset(input int unsigned size);
        return OffData + size;
    endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// Sender-side link of the packet arbiter: data/empty towards the sender, pop/address back.
interface packet_arbiter_if
    import router_pkg::*;
#(
    parameter int unsigned UWIDTH    = DefUwidth,
    parameter int unsigned PTR_IN_SZ = DefPtrInSz
) ();

    logic                 s_rempty;
    logic [UWIDTH-1:0]    s_rdata;
    logic                 s_rinc;
    logic [PTR_IN_SZ-1:0] s_raddr_in;
    logic                 s_abort;

    modport master (
        output s_rempty,
        output s_rdata,
        output s_abort,
        input  s_rinc,
        input  s_raddr_in
    );

    modport slave (
        input  s_rempty,
        input  s_rdata,
        input  s_abort,
        output s_rinc,
        output s_raddr_in
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping mod NPORTS.
module rr_picker #(
    parameter int unsigned NPORTS = 4
) (
    input  logic [NPORTS-1:0]         req_i,
    input  logic [$clog2(NPORTS)-1:0] last_i,
    output logic                      valid_o,
    output logic [NPORTS-1:0]         sel_o
);

    localparam int unsigned LW = $clog2(NPORTS);

    logic [LW-1:0] idx;

    always_comb begin
        valid_o = 1'b0;
        sel_o   = '0;
        idx     = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            idx = LW'((32'(last_i) + k) % NPORTS);
            if (!valid_o && req_i[idx]) begin
                valid_o    = 1'b1;
                sel_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one packet sender between NPORTS FIFOs,
// with a watchdog that releases a grant the sender never closes.
module packet_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NPORTS    = 4,
    parameter int unsigned UWIDTH    = DefUwidth,
    parameter int unsigned PTR_IN_SZ = DefPtrInSz,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        f_rempty,
    input  logic [NPORTS*UWIDTH-1:0] f_rdata,
    output logic [NPORTS-1:0]        f_rinc,
    output logic [PTR_IN_SZ-1:0]     f_raddr_in,
    packet_arbiter_if.master         sif,
    output logic [NPORTS-1:0]        grant,
    output logic                     busy
);

    localparam int unsigned LW  = $clog2(NPORTS);
    localparam int unsigned WdW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = (TIMEOUT == 0) ? '0 : WdW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [LW-1:0]     last_q, last_d;
    logic [WdW-1:0]    wd_cnt_q, wd_cnt_d;

    logic              pick_valid;
    logic [NPORTS-1:0] pick_sel;
    logic [LW-1:0]     gidx;
    logic              wd_fire;

    rr_picker #(
        .NPORTS (NPORTS)
    ) u_picker (
        .req_i   (~f_rempty),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .sel_o   (pick_sel)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) gidx = LW'(i);
        end
    end

    assign wd_fire = (TIMEOUT != 0) && (wd_cnt_q == WdLast);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        wd_cnt_d     = wd_cnt_q;
        f_rinc       = '0;
        sif.s_rempty = 1'b1;
        sif.s_rdata  = '0;
        sif.s_abort  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d  = pick_sel;
                    wd_cnt_d = '0;
                    state_d  = StLock;
                end
            end
            StLock: begin
                sif.s_rempty = f_rempty[gidx];
                sif.s_rdata  = f_rdata[int'(gidx)*UWIDTH +: UWIDTH];
                if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 1'b1;
                // A real pop always beats the watchdog; the abort path leaves the packet queued.
                if (sif.s_rinc) begin
                    f_rinc[gidx] = 1'b1;
                    last_d       = gidx;
                    grant_d      = '0;
                    state_d      = StIdle;
                end else if (wd_fire) begin
                    sif.s_abort = 1'b1;
                    last_d      = gidx;
                    grant_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= LW'(NPORTS - 1);
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == StLock);
    assign f_raddr_in = sif.s_raddr_in;

endmodule

// File: tb/tb_packet_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a packet-level model.
module tb_packet_arbiter;

    localparam int NP = 4;
    localparam int UW = 8;
    localparam int PW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    f_rempty;
    logic [NP*UW-1:0] f_rdata;
    logic [NP-1:0]    f_rinc;
    logic [PW-1:0]    f_raddr_in;
    logic [NP-1:0]    grant;
    logic             busy;

    packet_arbiter_if #(.UWIDTH(UW), .PTR_IN_SZ(PW)) sif ();

    packet_arbiter #(
        .NPORTS    (NP),
        .UWIDTH    (UW),
        .PTR_IN_SZ (PW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f_rempty   (f_rempty),
        .f_rdata    (f_rdata),
        .f_rinc     (f_rinc),
        .f_raddr_in (f_raddr_in),
        .sif        (sif),
        .grant      (grant),
        .busy       (busy)
    );

    // FIFO contents as queues of packet ids; word values derive from id and address.
    int fq [NP][$];
    int next_id = 1;

    // Packet-level reference: who holds the grant, who was served last, cycles held.
    bit m_busy;
    int m_g, m_last, m_cnt;

    int n_pass = 0, n_total = 0, n_fail = 0;
    logic [NP-1:0] obs_rinc;
    logic obs_busy, obs_abort;
    int gseq[$];
    logic [7:0] exp_pkt [7] = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word(input int id, input int a);
        if (id == 0) begin
            case (a)
                0: return 8'd10;
                1: return 8'd160;
                2: return 8'd3;
                3: return 8'd0;
                4: return 8'd1;
                5: return 8'd2;
                6: return 8'd15;
                default: return 8'd0;
            endcase
        end
        return 8'((id * 37 + a * 11 + 5) & 255);
    endfunction

    function automatic int onehot2idx(input logic [NP-1:0] g);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NP; i++) if (g[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    task automatic drive_fifo();
        for (int i = 0; i < NP; i++) begin
            f_rempty[i] = (fq[i].size() == 0);
            f_rdata[i*UW +: UW] = (fq[i].size() > 0) ? word(fq[i][0], int'(sif.s_raddr_in)) : 8'd0;
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = NP - 1;
        m_cnt  = 0;
    endtask

    // One clock cycle: check outputs against the model, advance the model, pop FIFOs on f_rinc.
    task automatic step();
        logic [NP-1:0] eg, ef;
        logic [UW-1:0] ed;
        logic er, ea;
        bit found;
        int p;
        drive_fifo();
        #1;
        if (m_busy) begin
            eg = NP'(1) << m_g;
            er = (fq[m_g].size() == 0);
            ed = er ? 8'd0 : word(fq[m_g][0], int'(sif.s_raddr_in));
            ef = sif.s_rinc ? eg : '0;
            ea = !sif.s_rinc && (m_cnt == TO);
        end else begin
            eg = '0; er = 1'b1; ed = '0; ef = '0; ea = 1'b0;
        end
        check("grant", grant, eg);
        check("busy", busy, m_busy);
        check("s_rempty", sif.s_rempty, er);
        check("s_rdata", sif.s_rdata, ed);
        check("f_rinc", f_rinc, ef);
        check("s_abort", sif.s_abort, ea);
        check("f_raddr_in", f_raddr_in, sif.s_raddr_in);
        obs_rinc  = f_rinc;
        obs_busy  = busy;
        obs_abort = sif.s_abort;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (!found && fq[p].size() > 0) begin
                    found = 1'b1; m_busy = 1'b1; m_g = p; m_cnt = 1;
                end
            end
        end else if (sif.s_rinc || ea) begin
            m_last = m_g;
            m_busy = 1'b0;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        for (int i = 0; i < NP; i++) if (obs_rinc[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        #1;
    endtask

    task automatic wait_grant(output bit ok);
        int w = 0;
        while (!m_busy && w < 20) begin step(); w++; end
        ok = m_busy;
        if (!ok) check("grant_wait_timeout", m_busy, 1);
    endtask

    // Wait for a grant, record the granted port, hold it `hold` cycles, then pop.
    task automatic serve(input int hold, output int idle);
        int w = 0;
        idle = 0;
        sif.s_rinc = 1'b0;
        while (!m_busy && w < 20) begin
            step();
            if (!obs_busy) idle++;
            w++;
        end
        if (!m_busy) begin
            check("serve_grant_timeout", m_busy, 1);
            return;
        end
        gseq.push_back(onehot2idx(grant));
        repeat (hold - 1) step();
        sif.s_rinc = 1'b1;
        step();
        sif.s_rinc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int idle, cnt;
        bit ok;
        sif.s_rinc = 1'b0;
        sif.s_raddr_in = '0;
        model_reset();
        drive_fifo();
        #12;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_s_rempty", sif.s_rempty, 1);
        check("rst_s_abort", sif.s_abort, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single requester on port 2.
        fq[2].push_back(0);
        step();
        check("single_grant", grant, 4'b0100);
        for (int a = 0; a < 7; a++) begin
            sif.s_raddr_in = PW'(a);
            drive_fifo(); #1;
            check("single_word", sif.s_rdata, exp_pkt[a]);
            step();
        end
        sif.s_rinc = 1'b1;
        step();
        check("single_rinc", obs_rinc, 4'b0100);
        sif.s_rinc = 1'b0;
        step();
        check("single_idle", obs_busy, 0);

        // Reset while port 1 is granted.
        fq[1].push_back(next_id++);
        wait_grant(ok);
        step();
        rst = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_s_rempty", sif.s_rempty, 1);
        check("midrst_busy", busy, 0);
        model_reset();
        #2;
        rst = 1'b1;
        fq[0].push_back(next_id++);
        gseq.delete();
        serve(4, idle);
        serve(4, idle);
        check("midrst_first", gseq[0], 0);
        check("midrst_second", gseq[1], 1);

        // Idle reset to restore last = NPORTS-1, then round-robin over all four ports.
        rst = 1'b0; #1; model_reset(); #2; rst = 1'b1;
        for (int i = 0; i < NP; i++) fq[i].push_back(next_id++);
        gseq.delete();
        for (int r = 0; r < NP; r++) begin
            serve(8, idle);
            check("rr_gap", idle, 1);
        end
        for (int r = 0; r < NP; r++) check("rr_order", gseq[r], r);

        // Ports 0 and 3 continuously loaded: must alternate.
        for (int i = 0; i < 4; i++) begin
            fq[0].push_back(next_id++);
            fq[3].push_back(next_id++);
        end
        gseq.delete();
        repeat (8) serve(3, idle);
        for (int r = 0; r < 8; r++) check("fair_order", gseq[r], (r % 2) ? 3 : 0);

        // Watchdog on port 1, sender never pops.
        fq[1].push_back(next_id++);
        wait_grant(ok);
        cnt = 0;
        obs_abort = 1'b0;
        while (!obs_abort && cnt < 40) begin step(); cnt++; end
        check("wd_cycles", cnt, TO);
        check("wd_pkt_kept", fq[1].size(), 1);
        fq[2].push_back(next_id++);
        gseq.delete();
        serve(4, idle);
        serve(4, idle);
        check("wd_next_port2", gseq[0], 2);
        check("wd_then_port1", gseq[1], 1);

        // Pop in the watchdog-fire cycle: normal release wins.
        fq[0].push_back(next_id++);
        wait_grant(ok);
        repeat (TO - 1) step();
        sif.s_rinc = 1'b1;
        step();
        check("simul_rinc", obs_rinc, 4'b0001);
        check("simul_abort", obs_abort, 0);
        repeat (5) begin
            step();
            check("idle_rinc", obs_rinc, 0);
        end
        sif.s_rinc = 1'b0;

        // Random traffic against the model.
        repeat (600) begin
            if ($urandom_range(0, 4) == 0) begin
                int p = int'($urandom_range(0, NP - 1));
                if (fq[p].size() < 4) fq[p].push_back(next_id++);
            end
            sif.s_raddr_in = PW'($urandom_range(0, 15));
            sif.s_rinc = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 7) == 0);
            step();
        end
        sif.s_rinc = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
